// File: rtl/exe_wb_queue.sv
// exe_wb_queue: in-order result queue between Execute and Writeback.
// Buffers up to DEPTH completed instruction bundles and presents them to
// Writeback oldest-first. It also counts retired (popped) bundles.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   flush             drop every queued entry (retired is kept)
//   in_valid/in_ready Execute-side handshake; in_* carry the bundle payload
//   out_valid/out_ready Writeback-side handshake; out_* show the head entry,
//                     and are zero while the queue is empty
//   count             current occupancy (0..DEPTH)
//   retired           number of completed out handshakes (wraps)
module exe_wb_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-3:0]   in_addr,
    input  logic [31:0]             in_insn,
    input  logic [4:0]              in_rd,
    input  logic                    in_we,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-3:0]   out_addr,
    output logic [31:0]             out_insn,
    output logic [4:0]              out_rd,
    output logic                    out_we,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             retired
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-3:0] addr;
        logic [31:0]           insn;
        logic [4:0]            rd;
        logic                  we;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push;
    logic          pop;

    // Ready comes only from registered occupancy: a full queue never
    // accepts in the same cycle it pops.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            retired <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) begin
                rp      <= rp + PW'(1);
                retired <= retired + 32'd1;
            end
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Payload storage is not reset; an entry is only visible while counted.
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= '{addr: in_addr, insn: in_insn, rd: in_rd, we: in_we, data: in_data};
    end

    assign head     = mem[rp];
    assign out_addr = out_valid ? head.addr : '0;
    assign out_insn = out_valid ? head.insn : '0;
    assign out_rd   = out_valid ? head.rd   : '0;
    assign out_we   = out_valid ? head.we   : 1'b0;
    assign out_data = out_valid ? head.data : '0;

endmodule

// File: tb/tb_exe_wb_queue.sv
// Self-checking bench for exe_wb_queue: a queue scoreboard records bundles
// as they are accepted and compares them with the head as they are popped,
// plus directed checks of reset, back-pressure, streaming, flush and reset.
module tb_exe_wb_queue;
    localparam int AW = 32;
    localparam int DEPTH = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-3:0] addr;
        logic [31:0]   insn;
        logic [4:0]    rd;
        logic          we;
        logic [DW-1:0] data;
    } bund_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [AW-3:0]          in_addr = '0;
    logic [31:0]            in_insn = '0;
    logic [4:0]             in_rd = '0;
    logic                   in_we = 1'b0;
    logic [DW-1:0]          in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [AW-3:0]          out_addr;
    logic [31:0]            out_insn;
    logic [4:0]             out_rd;
    logic                   out_we;
    logic [DW-1:0]          out_data;
    logic [$clog2(DEPTH):0] count;
    logic [31:0]            retired;

    exe_wb_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_insn(in_insn), .in_rd(in_rd), .in_we(in_we), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_insn(out_insn), .out_rd(out_rd), .out_we(out_we), .out_data(out_data),
        .count(count), .retired(retired)
    );

    always #5 clk = ~clk;

    bund_t       out_b;
    assign out_b = {out_addr, out_insn, out_rd, out_we, out_data};

    bund_t       sb[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_retired = '0;
    logic        pushed = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] addr, input logic [31:0] insn,
                          input logic [4:0] rd, input logic we, input logic [31:0] data);
        in_valid = v;
        in_addr  = addr[AW-3:0];
        in_insn  = insn;
        in_rd    = rd;
        in_we    = we;
        in_data  = data;
    endtask

    // One clock: check outputs against the scoreboard mid-cycle, then apply
    // the handshakes that the coming edge performs to the model.
    task automatic cycle();
        logic  do_push, do_pop;
        bund_t cur;
        @(negedge clk);
        if (rst) begin
            chk("count", 128'(count), 128'(sb.size()));
            chk("in_ready", 128'(in_ready), 128'(sb.size() != DEPTH));
            chk("out_valid", 128'(out_valid), 128'(sb.size() != 0));
            chk("retired", 128'(retired), 128'(m_retired));
            if (sb.size() != 0) chk("head", 128'(out_b), 128'(sb[0]));
            else                chk("empty_payload", 128'(out_b), 128'(0));
        end
        do_push = rst && !flush && in_valid && (sb.size() != DEPTH);
        do_pop  = rst && !flush && out_ready && (sb.size() != 0);
        cur = {in_addr, in_insn, in_rd, in_we, in_data};
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            m_retired = '0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                pop_log.push_back(sb[0].insn);
                void'(sb.pop_front());
                m_retired++;
            end
            if (do_push) sb.push_back(cur);
        end
        pushed = do_push;
        #1;
    endtask

    // Present one bundle and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] insn);
        int n;
        set_in(1'b1, 32'h40 + insn, insn, insn[4:0], insn[0], insn ^ 32'h5a5a0000);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!pushed && n < 50);
        if (!pushed) chk("send_timeout", 128'(0), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [31:0] r0;
        int          p0;

        // Reset then single push
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_payload", 128'(out_b), 128'(0));
        chk("rst_retired", 128'(retired), 128'(0));
        set_in(1'b1, 32'h100, 32'h00500093, 5'd1, 1'b1, 32'd5);
        cycle();
        in_valid = 1'b0;
        chk("t1_out_valid", 128'(out_valid), 128'(1));
        chk("t1_out_addr", 128'(out_addr), 128'(32'h100));
        chk("t1_out_insn", 128'(out_insn), 128'(32'h00500093));
        chk("t1_out_rd", 128'(out_rd), 128'(1));
        chk("t1_out_we", 128'(out_we), 128'(1));
        chk("t1_out_data", 128'(out_data), 128'(5));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t1_retired", 128'(retired), 128'(1));
        chk("t1_count", 128'(count), 128'(0));

        // Fill and back-pressure
        r0 = retired;
        p0 = pop_log.size();
        for (int i = 1; i <= 4; i++) send(i);
        chk("fill_in_ready", 128'(in_ready), 128'(0));
        chk("fill_count", 128'(count), 128'(DEPTH));
        set_in(1'b1, 32'h45, 32'd5, 5'd5, 1'b1, 32'd5 ^ 32'h5a5a0000);
        for (int i = 0; i < 3; i++) cycle();
        chk("fill_held", 128'(count), 128'(DEPTH));
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || in_valid); i++) begin
            cycle();
            if (pushed) in_valid = 1'b0;
        end
        chk("fill_pops", 128'(pop_log.size() - p0), 128'(5));
        for (int i = 0; i < 5; i++)
            if (p0 + i < pop_log.size()) chk("fill_order", 128'(pop_log[p0+i]), 128'(i + 1));
        chk("fill_retired", 128'(retired), 128'(r0 + 5));

        // Streaming and wrap
        r0 = retired;
        p0 = pop_log.size();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'h200 + i, i, 5'(i), 1'b1, 32'(i * 3));
            cycle();
            if (i > 0) chk("stream_count", 128'(count), 128'(1));
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_pops", 128'(pop_log.size() - p0), 128'(20));
        for (int i = 0; i < 20; i++)
            if (p0 + i < pop_log.size()) chk("stream_order", 128'(pop_log[p0+i]), 128'(i));
        chk("stream_retired", 128'(retired), 128'(r0 + 20));

        // Flush with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h70 + i);
        chk("flush_pre_count", 128'(count), 128'(3));
        r0 = retired;
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h300, 32'hdead, 5'd9, 1'b1, 32'hbeef);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_payload", 128'(out_b), 128'(0));
        chk("flush_retired", 128'(retired), 128'(r0));

        // Reset mid-stream
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(32'h80 + i);
            drain();
            out_ready = 1'b0;
        end
        send(32'h90);
        send(32'h91);
        chk("mid_pre_count", 128'(count), 128'(2));
        chk("mid_pre_retired", 128'(retired), 128'(7));
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("mid_count", 128'(count), 128'(0));
        chk("mid_retired", 128'(retired), 128'(0));
        chk("mid_in_ready", 128'(in_ready), 128'(1));
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        send(32'habc);
        chk("mid_first_out", 128'(out_insn), 128'(32'habc));
        drain();

        // Random stress
        r0 = retired;
        p0 = pop_log.size();
        in_valid = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || pushed)
                set_in(1'($urandom_range(1)), $urandom, $urandom, 5'($urandom), 1'($urandom),
                       $urandom);
            out_ready = 1'($urandom_range(1));
            cycle();
        end
        in_valid = 1'b0;
        drain();
        chk("stress_retired", 128'(retired), 128'(r0 + 32'(pop_log.size() - p0)));
        chk("stress_empty", 128'(count), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
